// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide unit owning the HI/LO register pair.
// Executes MULT, MULTU, DIV and DIVU one bit per cycle (WIDTH iterations),
// accepts MTHI/MTLO writes when idle and drives HI/LO continuously.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   i_start       launch an operation (sampled only when not busy)
//   i_op          00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   i_src_a       rs operand (multiplicand / dividend)
//   i_src_b       rt operand (multiplier / divisor)
//   i_hilo_wr     01 MTLO, 10 MTHI, 00/11 no write
//   i_hilo_wdata  data for MTHI/MTLO
//   o_hi, o_lo    HI and LO registers
//   o_busy        operation in flight; pipeline must stall
//   o_done        one-cycle pulse when HI/LO hold a new result
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  input  logic [1:0]       i_hilo_wr,
  input  logic [WIDTH-1:0] i_hilo_wdata,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIXUP,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_op;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_negRes;
  logic                 r_negRem;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  // op[1] selects divide, op[0] selects the unsigned variant
  logic                 w_isDiv;
  logic                 w_isSigned;
  logic                 w_negA;
  logic                 w_negB;
  logic [WIDTH-1:0]     w_absA;
  logic [WIDTH-1:0]     w_absB;
  logic                 w_divZero;
  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH:0]       w_mulSum;
  logic [2*WIDTH-1:0]   w_mulNext;
  logic [WIDTH:0]       w_shRem;
  logic                 w_divOk;
  logic [WIDTH-1:0]     w_remSub;
  logic [2*WIDTH-1:0]   w_divNext;
  logic [2*WIDTH-1:0]   w_product;
  logic [WIDTH-1:0]     w_quot;
  logic [WIDTH-1:0]     w_rem;

  assign w_isDiv    = r_op[1];
  assign w_isSigned = ~r_op[0];
  assign w_negA     = w_isSigned & r_a[WIDTH-1];
  assign w_negB     = w_isSigned & r_b[WIDTH-1];
  assign w_absA     = w_negA ? -r_a : r_a;
  assign w_absB     = w_negB ? -r_b : r_b;
  assign w_divZero  = w_isDiv && (r_b == '0);

  // Shift-add: add the multiplicand to the upper half when the multiplier
  // LSB (bottom of the accumulator) is set, then shift the pair right.
  assign w_addend  = r_acc[0] ? r_a : '0;
  assign w_mulSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_mulNext = {w_mulSum, r_acc[WIDTH-1:1]};

  // Restoring division: the partial remainder shifted left by one needs
  // WIDTH+1 bits; when it fits the divisor the difference fits in WIDTH bits.
  assign w_shRem   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_divOk   = w_shRem >= {1'b0, r_b};
  assign w_remSub  = w_shRem[WIDTH-1:0] - r_b;
  assign w_divNext = w_divOk ? {w_remSub, r_acc[WIDTH-2:0], 1'b1}
                             : {r_acc[2*WIDTH-2:0], 1'b0};

  // Sign restoration: full-width negate for products, independent negates
  // for quotient and remainder.
  assign w_product = r_negRes ? -r_acc : r_acc;
  assign w_quot    = r_negRes ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem     = r_negRem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  assign o_hi = r_hi;
  assign o_lo = r_lo;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic and status outputs; divide-by-zero bypasses CALC
  always_comb begin
    w_next = r_state;
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_PREP;
      S_PREP: begin
        o_busy = 1'b1;
        w_next = w_divZero ? S_DONE : S_CALC;
      end
      S_CALC: begin
        o_busy = 1'b1;
        if (r_cnt == CNT_W'(WIDTH-1)) w_next = S_FIXUP;
      end
      S_FIXUP: begin
        o_busy = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = i_start ? S_PREP : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, result and MTHI/MTLO writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_negRes <= 1'b0;
      r_negRem <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // start takes priority over a simultaneous HI/LO write
          if (i_start) begin
            r_op <= i_op;
            r_a  <= i_src_a;
            r_b  <= i_src_b;
          end else if (i_hilo_wr == 2'b01) begin
            r_lo <= i_hilo_wdata;
          end else if (i_hilo_wr == 2'b10) begin
            r_hi <= i_hilo_wdata;
          end
        end
        S_PREP: begin
          r_cnt    <= '0;
          r_negRes <= w_negA ^ w_negB;
          r_negRem <= w_negA;
          r_a      <= w_absA;
          r_b      <= w_absB;
          if (w_divZero) begin
            r_hi  <= r_a;
            r_lo  <= '1;
            r_acc <= '0;
          end else begin
            r_acc <= w_isDiv ? {{WIDTH{1'b0}}, w_absA} : {{WIDTH{1'b0}}, w_absB};
          end
        end
        S_CALC: begin
          r_acc <= w_isDiv ? w_divNext : w_mulNext;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_FIXUP: begin
          if (w_isDiv) begin
            r_lo <= w_quot;
            r_hi <= w_rem;
          end else begin
            r_hi <= w_product[2*WIDTH-1:WIDTH];
            r_lo <= w_product[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: self-checking bench for muldiv_seq. A cycle-count model
// computes results with plain 64-bit arithmetic and is compared against the
// DUT every cycle; directed cases pin literal results and the handshake.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [1:0]  i_op = 2'b00;
  logic [31:0] i_src_a = '0;
  logic [31:0] i_src_b = '0;
  logic [1:0]  i_hilo_wr = 2'b00;
  logic [31:0] i_hilo_wdata = '0;
  logic [31:0] o_hi;
  logic [31:0] o_lo;
  logic        o_busy;
  logic        o_done;

  int nChecks = 0;
  int nFails = 0;
  bit checkEn = 1'b0;

  muldiv_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_start(i_start),
    .i_op(i_op),
    .i_src_a(i_src_a),
    .i_src_b(i_src_b),
    .i_hilo_wr(i_hilo_wr),
    .i_hilo_wdata(i_hilo_wdata),
    .o_hi(o_hi),
    .o_lo(o_lo),
    .o_busy(o_busy),
    .o_done(o_done)
  );

  always #5 clk = ~clk;

  // Reference result {hi, lo} straight from the arithmetic definitions
  function automatic logic [63:0] refResult(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin
        p = sa * sb;
        return p;
      end
      2'b01: return {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Behavioural model: results appear 35 cycles after start (2 for /0)
  logic [31:0] mHi = '0, mLo = '0, resHi = '0, resLo = '0;
  logic        mBusy = 1'b0, mDone = 1'b0;
  int          mLeft = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mHi <= '0; mLo <= '0; mBusy <= 1'b0; mDone <= 1'b0; mLeft <= 0;
    end else begin
      mDone <= 1'b0;
      if (mBusy) begin
        if (mLeft == 1) begin
          mBusy <= 1'b0;
          mDone <= 1'b1;
          mHi   <= resHi;
          mLo   <= resLo;
        end else begin
          mLeft <= mLeft - 1;
        end
      end else if (i_start) begin
        {resHi, resLo} <= refResult(i_op, i_src_a, i_src_b);
        mBusy <= 1'b1;
        mLeft <= (i_op[1] && i_src_b == 0) ? 1 : 34;
      end else if (i_hilo_wr == 2'b01) begin
        mLo <= i_hilo_wdata;
      end else if (i_hilo_wr == 2'b10) begin
        mHi <= i_hilo_wdata;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("cyc_busy", 32'(o_busy), 32'(mBusy));
      checkOutput("cyc_done", 32'(o_done), 32'(mDone));
      checkOutput("cyc_hi", o_hi, mHi);
      checkOutput("cyc_lo", o_lo, mLo);
    end
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    i_start   = 1'b1;
    i_op      = op;
    i_src_a   = a;
    i_src_b   = b;
    i_hilo_wr = 2'b00;
  endtask

  task automatic waitDone(output int doneCycle, output int busyCycles);
    doneCycle  = -1;
    busyCycles = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (o_busy) busyCycles++;
      if (o_done) begin
        doneCycle = k;
        break;
      end
    end
  endtask

  task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int doneCycle, output int busyCycles);
    @(negedge clk);
    applyStimulus(op, a, b);
    waitDone(doneCycle, busyCycles);
  endtask

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dc, bc, nDone;
    logic [63:0] pin;

    // Model pins against hand-computed values
    pin = refResult(2'b10, 32'hFFFF_FFF9, 32'd2);
    checkOutput("model_div_lo", pin[31:0], 32'hFFFF_FFFD);
    checkOutput("model_div_hi", pin[63:32], 32'hFFFF_FFFF);
    pin = refResult(2'b00, 32'hFFFF_FFFE, 32'd3);
    checkOutput("model_mult_hi", pin[63:32], 32'hFFFF_FFFF);
    checkOutput("model_mult_lo", pin[31:0], 32'hFFFF_FFFA);

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_hi", o_hi, 32'h0);
    checkOutput("rst_lo", o_lo, 32'h0);
    checkOutput("rst_busy", 32'(o_busy), 32'h0);
    checkOutput("rst_done", 32'(o_done), 32'h0);
    rst_n = 1'b1;
    checkEn = 1'b1;

    // MTLO / MTHI while idle
    @(negedge clk);
    i_hilo_wr = 2'b01; i_hilo_wdata = 32'h1234;
    @(negedge clk);
    checkOutput("mtlo", o_lo, 32'h1234);
    i_hilo_wr = 2'b10; i_hilo_wdata = 32'hABCD;
    @(negedge clk);
    i_hilo_wr = 2'b00;
    checkOutput("mthi", o_hi, 32'hABCD);

    // Directed arithmetic cases
    runOp(2'b00, 32'hFFFF_FFFE, 32'd3, dc, bc);
    checkOutput("mult_cycle", 32'(dc), 32'd35);
    checkOutput("mult_busy_cycles", 32'(bc), 32'd34);
    checkOutput("mult_hi", o_hi, 32'hFFFF_FFFF);
    checkOutput("mult_lo", o_lo, 32'hFFFF_FFFA);

    runOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dc, bc);
    checkOutput("multu_hi", o_hi, 32'hFFFF_FFFE);
    checkOutput("multu_lo", o_lo, 32'h0000_0001);

    runOp(2'b10, 32'hFFFF_FFF9, 32'd2, dc, bc);
    checkOutput("div_cycle", 32'(dc), 32'd35);
    checkOutput("div_lo", o_lo, 32'hFFFF_FFFD);
    checkOutput("div_hi", o_hi, 32'hFFFF_FFFF);

    runOp(2'b11, 32'd7, 32'd2, dc, bc);
    checkOutput("divu_lo", o_lo, 32'd3);
    checkOutput("divu_hi", o_hi, 32'd1);

    runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, dc, bc);
    checkOutput("divovf_lo", o_lo, 32'h8000_0000);
    checkOutput("divovf_hi", o_hi, 32'h0);

    runOp(2'b11, 32'd100, 32'd0, dc, bc);
    checkOutput("div0_cycle", 32'(dc), 32'd2);
    checkOutput("div0_hi", o_hi, 32'h64);
    checkOutput("div0_lo", o_lo, 32'hFFFF_FFFF);

    // start and hilo_wr while busy are both ignored
    @(negedge clk);
    applyStimulus(2'b00, 32'd5, 32'd6);
    dc = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      i_start      = (k == 5);
      i_op         = (k == 5) ? 2'b11 : 2'b00;
      i_src_a      = (k == 5) ? 32'd99 : 32'd5;
      i_src_b      = (k == 5) ? 32'd7 : 32'd6;
      i_hilo_wr    = (k == 5) ? 2'b01 : 2'b00;
      i_hilo_wdata = 32'hDEAD;
      if (o_done) begin
        dc = k;
        break;
      end
    end
    i_start = 1'b0; i_hilo_wr = 2'b00;
    checkOutput("ign_cycle", 32'(dc), 32'd35);
    checkOutput("ign_hi", o_hi, 32'h0);
    checkOutput("ign_lo", o_lo, 32'd30);

    // Back-to-back: start in the DONE cycle is accepted
    runOp(2'b01, 32'd2, 32'd3, dc, bc);
    checkOutput("b2b_first_lo", o_lo, 32'd6);
    applyStimulus(2'b11, 32'd9, 32'd2);
    waitDone(dc, bc);
    checkOutput("b2b_cycle", 32'(dc), 32'd35);
    checkOutput("b2b_busy_cycles", 32'(bc), 32'd34);
    checkOutput("b2b_lo", o_lo, 32'd4);
    checkOutput("b2b_hi", o_hi, 32'd1);

    // Reset in the middle of a MULT aborts with no done pulse
    @(negedge clk);
    applyStimulus(2'b00, 32'd1234, 32'd5678);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      i_start = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_hi", o_hi, 32'h0);
    checkOutput("abort_lo", o_lo, 32'h0);
    checkOutput("abort_busy", 32'(o_busy), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nDone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_done) nDone++;
    end
    checkOutput("abort_no_done", 32'(nDone), 32'h0);
    checkOutput("abort_idle", 32'(o_busy), 32'h0);

    // Random traffic, including start/hilo_wr while busy and collisions
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      i_start      = ($urandom_range(0, 3) == 0);
      i_op         = 2'($urandom_range(0, 3));
      i_src_a      = randOperand();
      i_src_b      = randOperand();
      i_hilo_wr    = 2'($urandom_range(0, 3));
      i_hilo_wdata = $urandom;
    end
    @(negedge clk);
    i_start = 1'b0;
    i_hilo_wr = 2'b00;
    repeat (40) @(negedge clk);

    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
